// File: rtl/sand_pkg.sv
// Shared constants for the sand command queue: register map and STATUS layout.
package sand_pkg;

    localparam logic [2:0] ADDR_X      = 3'd0;
    localparam logic [2:0] ADDR_Y      = 3'd1;
    localparam logic [2:0] ADDR_RADIUS = 3'd2;
    localparam logic [2:0] ADDR_TYPE   = 3'd3;
    localparam logic [2:0] ADDR_COMMIT = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;
    localparam logic [2:0] ADDR_FLUSH  = 3'd6;

    localparam int unsigned STAT_EMPTY   = 0;
    localparam int unsigned STAT_FULL    = 1;
    localparam int unsigned STAT_OVF     = 2;
    localparam int unsigned STAT_CNT_LSB = 8;
    localparam int unsigned STAT_CNT_W   = 8;

endpackage

// File: rtl/sand_cmd_fifo.sv
// Show-ahead FIFO with single-cycle flush; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sand_cmd_fifo #(
    parameter int unsigned WIDTH = 26,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_flush,
    input  logic [WIDTH-1:0]             i_wr_data,
    output logic [WIDTH-1:0]             o_rd_data_c,
    output logic                         o_full_c,
    output logic                         o_empty_c,
    output logic [$clog2(DEPTH):0]       o_count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_full_c    = (r_count == CNT_W'(DEPTH));
    assign o_empty_c   = (r_count == '0);
    assign o_rd_data_c = r_mem[r_rd_ptr];
    assign o_count     = r_count;

    assign w_do_pop  = i_pop && !o_empty_c;
    assign w_do_push = i_push && (!o_full_c || w_do_pop);

    // Storage needs no reset: head contents are ignored while empty.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Flush takes priority over any same-cycle push or pop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sand_cmd_queue.sv
// HPS-facing brush command register block feeding a show-ahead command FIFO.
// Shadow registers are snapshotted into the FIFO on a COMMIT write.
module sand_cmd_queue
    import sand_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned COORD_W  = 8,
    parameter int unsigned RADIUS_W = 8,
    parameter int unsigned TYPE_W   = 2,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                kernel_chipselect,
    input  logic                kernel_write,
    input  logic                kernel_read,
    input  logic [2:0]          kernel_address,
    input  logic [DATA_W-1:0]   kernel_writedata,
    output logic [DATA_W-1:0]   kernel_readdata,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic [COORD_W-1:0]  cmd_x,
    output logic [COORD_W-1:0]  cmd_y,
    output logic [RADIUS_W-1:0] cmd_radius,
    output logic [TYPE_W-1:0]   cmd_type
);

    localparam int unsigned ENTRY_W = 2 * COORD_W + RADIUS_W + TYPE_W;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

    logic [COORD_W-1:0]  r_x;
    logic [COORD_W-1:0]  r_y;
    logic [RADIUS_W-1:0] r_radius;
    logic [TYPE_W-1:0]   r_type;
    logic                r_overflow;
    logic [DATA_W-1:0]   r_readdata;

    logic                w_wr;
    logic                w_rd;
    logic                w_commit;
    logic                w_flush;
    logic                w_clr_ovf;
    logic                w_pop;
    logic                w_drop;
    logic                w_full;
    logic                w_empty;
    logic [CNT_W-1:0]    w_count;
    logic [ENTRY_W-1:0]  w_head;
    logic [DATA_W-1:0]   w_status;
    logic [DATA_W-1:0]   w_rd_mux;
    logic                w_unused_wdata;

    assign w_wr      = kernel_chipselect && kernel_write;
    assign w_rd      = kernel_chipselect && kernel_read;
    assign w_commit  = w_wr && (kernel_address == ADDR_COMMIT);
    assign w_flush   = w_wr && (kernel_address == ADDR_FLUSH);
    assign w_clr_ovf = w_wr && (kernel_address == ADDR_STATUS) && kernel_writedata[0];
    assign w_pop     = cmd_valid && cmd_ready;
    assign w_drop    = w_commit && w_full && !w_pop;

    // Only the low bits of each write are architecturally meaningful.
    assign w_unused_wdata = ^kernel_writedata;

    sand_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk       (clock),
        .i_rst       (reset),
        .i_push      (w_commit),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .i_wr_data   ({r_x, r_y, r_radius, r_type}),
        .o_rd_data_c (w_head),
        .o_full_c    (w_full),
        .o_empty_c   (w_empty),
        .o_count     (w_count)
    );

    assign cmd_valid = !w_empty;
    assign {cmd_x, cmd_y, cmd_radius, cmd_type} = w_head;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_x      <= '0;
            r_y      <= '0;
            r_radius <= '0;
            r_type   <= '0;
        end else if (w_wr) begin
            case (kernel_address)
                ADDR_X:      r_x      <= kernel_writedata[COORD_W-1:0];
                ADDR_Y:      r_y      <= kernel_writedata[COORD_W-1:0];
                ADDR_RADIUS: r_radius <= kernel_writedata[RADIUS_W-1:0];
                ADDR_TYPE:   r_type   <= kernel_writedata[TYPE_W-1:0];
                default:     ;
            endcase
        end
    end

    // Sticky overflow; clear and drop are mutually exclusive by address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_clr_ovf) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    always_comb begin
        w_status = '0;
        w_status[STAT_EMPTY] = w_empty;
        w_status[STAT_FULL]  = w_full;
        w_status[STAT_OVF]   = r_overflow;
        w_status[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(w_count);
    end

    always_comb begin
        w_rd_mux = '0;
        case (kernel_address)
            ADDR_X:      w_rd_mux = DATA_W'(r_x);
            ADDR_Y:      w_rd_mux = DATA_W'(r_y);
            ADDR_RADIUS: w_rd_mux = DATA_W'(r_radius);
            ADDR_TYPE:   w_rd_mux = DATA_W'(r_type);
            ADDR_STATUS: w_rd_mux = w_status;
            default:     w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (w_rd) begin
            r_readdata <= w_rd_mux;
        end
    end

    assign kernel_readdata = r_readdata;

endmodule

// File: tb/tb_sand_cmd_queue.sv
// Directed and randomized checks of sand_cmd_queue against a queue-based model.
module tb_sand_cmd_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        kernel_chipselect = 1'b0;
    logic        kernel_write = 1'b0;
    logic        kernel_read = 1'b0;
    logic [2:0]  kernel_address = 3'd0;
    logic [15:0] kernel_writedata = 16'd0;
    logic [15:0] kernel_readdata;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [7:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [7:0]  cmd_radius;
    logic [1:0]  cmd_type;

    int checks = 0;
    int errors = 0;
    bit rdy = 1'b0;

    // Reference model state
    logic [25:0] mq[$];
    logic [7:0]  m_x, m_y, m_r;
    logic [1:0]  m_t;
    bit          m_ovf;
    logic [15:0] exp_rd;

    sand_cmd_queue dut (
        .clock             (clock),
        .reset             (reset),
        .kernel_chipselect (kernel_chipselect),
        .kernel_write      (kernel_write),
        .kernel_read       (kernel_read),
        .kernel_address    (kernel_address),
        .kernel_writedata  (kernel_writedata),
        .kernel_readdata   (kernel_readdata),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_x             (cmd_x),
        .cmd_y             (cmd_y),
        .cmd_radius        (cmd_radius),
        .cmd_type          (cmd_type)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_x = '0; m_y = '0; m_r = '0; m_t = '0;
        m_ovf = 1'b0;
        exp_rd = '0;
    endtask

    function automatic logic [15:0] model_status();
        int n;
        n = mq.size();
        return {8'(n), 5'd0, m_ovf, (n == 8), (n == 0)};
    endfunction

    function automatic logic [15:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return {8'd0, m_x};
            3'd1: return {8'd0, m_y};
            3'd2: return {8'd0, m_r};
            3'd3: return {14'd0, m_t};
            3'd5: return model_status();
            default: return 16'd0;
        endcase
    endfunction

    // One bus cycle of behaviour computed from the pre-edge state.
    task automatic model_edge(input bit cs, input bit wr, input bit rd,
                              input logic [2:0] a, input logic [15:0] d, input bit rd_y);
        bit          pop;
        bit          commit;
        bit          flush;
        int          n0;
        logic [25:0] snap;
        n0     = mq.size();
        pop    = rd_y && (n0 > 0);
        snap   = {m_x, m_y, m_r, m_t};
        commit = cs && wr && (a == 3'd4);
        flush  = cs && wr && (a == 3'd6);
        if (cs && rd) exp_rd = model_read(a);
        if (cs && wr) begin
            case (a)
                3'd0: m_x = d[7:0];
                3'd1: m_y = d[7:0];
                3'd2: m_r = d[7:0];
                3'd3: m_t = d[1:0];
                3'd5: if (d[0]) m_ovf = 1'b0;
                default: ;
            endcase
        end
        if (flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (commit) begin
                if (n0 < 8 || pop) mq.push_back(snap);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("cmd_valid", 32'(cmd_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("cmd_fields", {6'd0, cmd_x, cmd_y, cmd_radius, cmd_type}, 32'(mq[0]));
        end
        chk("readdata", 32'(kernel_readdata), 32'(exp_rd));
    endtask

    task automatic step(input bit cs, input bit wr, input bit rd,
                        input logic [2:0] a, input logic [15:0] d);
        kernel_chipselect = cs;
        kernel_write      = wr;
        kernel_read       = rd;
        kernel_address    = a;
        kernel_writedata  = d;
        cmd_ready         = rdy;
        @(posedge clock);
        model_edge(cs, wr, rd, a, d, rdy);
        #1;
        kernel_chipselect = 1'b0;
        kernel_write      = 1'b0;
        kernel_read       = 1'b0;
        check_outputs();
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        step(1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        step(1'b1, 1'b0, 1'b1, a, 16'd0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("reset_valid", 32'(cmd_valid), 32'd0);
        chk("reset_rdata", 32'(kernel_readdata), 32'd0);
        rd(3'd5);
        chk("reset_status", 32'(kernel_readdata), 32'h0001);

        // Single commit, then status
        wr(3'd0, 16'h0012); wr(3'd1, 16'h0034); wr(3'd2, 16'h0005); wr(3'd3, 16'h0002);
        chk("pre_commit_valid", 32'(cmd_valid), 32'd0);
        wr(3'd4, 16'hffff);
        chk("commit_valid", 32'(cmd_valid), 32'd1);
        chk("commit_fields", {6'd0, cmd_x, cmd_y, cmd_radius, cmd_type}, {6'd0, 8'h12, 8'h34, 8'h05, 2'd2});
        rd(3'd5);
        chk("commit_status", 32'(kernel_readdata), 32'h0100);
        rdy = 1'b1; idle(); rdy = 1'b0;

        // Fill past full, then drain in order
        for (int i = 0; i < 9; i++) begin
            wr(3'd0, 16'(i));
            wr(3'd4, 16'd0);
        end
        rd(3'd5);
        chk("overflow_status", 32'(kernel_readdata), 32'h0806);
        rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_x", 32'(cmd_x), 32'(i));
            idle();
        end
        rdy = 1'b0;
        chk("drained_valid", 32'(cmd_valid), 32'd0);

        // Overflow clear needs bit 0 set
        wr(3'd5, 16'h0000); rd(3'd5);
        chk("ovf_kept", 32'(kernel_readdata), 32'h0005);
        wr(3'd5, 16'h0001); rd(3'd5);
        chk("ovf_cleared", 32'(kernel_readdata), 32'h0001);

        // Commit while full with same-cycle pop
        for (int i = 1; i <= 8; i++) begin
            wr(3'd0, 16'(i));
            wr(3'd4, 16'd0);
        end
        wr(3'd0, 16'h0099);
        rdy = 1'b1; wr(3'd4, 16'd0); rdy = 1'b0;
        rd(3'd5);
        chk("full_pop_status", 32'(kernel_readdata), 32'h0802);
        rdy = 1'b1;
        for (int i = 2; i <= 8; i++) begin
            chk("full_pop_drain", 32'(cmd_x), 32'(i));
            idle();
        end
        chk("full_pop_newest", 32'(cmd_x), 32'h99);
        idle();
        rdy = 1'b0;

        // Flush together with a pop
        for (int i = 0; i < 3; i++) begin
            wr(3'd0, 16'(8'h21 + i));
            wr(3'd4, 16'd0);
        end
        rdy = 1'b1; wr(3'd6, 16'd0); rdy = 1'b0;
        chk("flush_valid", 32'(cmd_valid), 32'd0);
        rd(3'd5);
        chk("flush_status", 32'(kernel_readdata), 32'h0001);
        rd(3'd0);
        chk("flush_keeps_x", 32'(kernel_readdata), 32'h0023);

        // Asynchronous reset between edges
        for (int i = 0; i < 5; i++) begin
            wr(3'd0, 16'(i + 1));
            wr(3'd4, 16'd0);
        end
        rd(3'd0);
        chk("pre_reset_valid", 32'(cmd_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_valid", 32'(cmd_valid), 32'd0);
        chk("async_reset_rdata", 32'(kernel_readdata), 32'd0);
        model_reset();
        @(posedge clock);
        #1 reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(3'(a));
            chk("post_reset_reg", 32'(kernel_readdata), 32'd0);
        end
        rd(3'd5);
        chk("post_reset_status", 32'(kernel_readdata), 32'h0001);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit          cs;
            bit          w;
            bit          r;
            logic [2:0]  a;
            logic [15:0] d;
            cs  = ($urandom_range(0, 9) != 0);
            w   = ($urandom_range(0, 2) != 0);
            r   = ($urandom_range(0, 2) == 0);
            a   = ($urandom_range(0, 2) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
            d   = 16'($urandom);
            rdy = ($urandom_range(0, 2) == 0);
            step(cs, w, r, a, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sand_cmd_queue.md
SAND_CMD_QUEUE -- requirements
Module: sand_cmd_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 16: HPS bus data width.
REQ-002 SHALL have parameter COORD_W, default 8: x/y width, COORD_W <= DATA_W.
REQ-003 SHALL have parameter RADIUS_W, default 8: brush radius width, RADIUS_W <= DATA_W.
REQ-004 SHALL have parameter TYPE_W, default 2: particle type width.
REQ-005 SHALL have parameter DEPTH, default 8: queue entries, a power of 2, 2..128.
REQ-006 SHALL have port clock, input, 1: the single clock.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port kernel_chipselect, input, 1: slave select.
REQ-009 SHALL have port kernel_write, input, 1: write strobe.
REQ-010 SHALL have port kernel_read, input, 1: read strobe.
REQ-011 SHALL have port kernel_address, input, 3: register index.
REQ-012 SHALL have port kernel_writedata, input, DATA_W: write payload.
REQ-013 SHALL have port kernel_readdata, output, DATA_W: read payload.
REQ-014 SHALL have ports cmd_valid, output, 1, and cmd_ready, input, 1: consumer handshake.
REQ-015 SHALL have ports cmd_x and cmd_y, output, COORD_W each, plus cmd_radius (RADIUS_W) and cmd_type (TYPE_W): head-entry fields.

Function
REQ-016 A write is accepted when chipselect && write at a clock edge; address 0/1/2/3 loads X/Y/RADIUS/TYPE from the writedata low bits.
REQ-017 A write to address 4 (COMMIT) pushes the snapshot {X,Y,RADIUS,TYPE} held before that edge into the queue; the data value is ignored.
REQ-018 A write to address 5 with writedata[0]=1 clears the sticky overflow flag.
REQ-019 A write to address 6 (FLUSH) empties the queue in one cycle; the shadow registers are unchanged.
REQ-020 Writes to address 7 have no effect.
REQ-021 Reads SHALL have 1-cycle latency: readdata registered on the edge where chipselect && read.
REQ-022 Read map: 0-3 return the zero-extended shadow registers; 5 returns STATUS; 4, 6 and 7 return 0.
REQ-023 STATUS SHALL be: [0] empty, [1] full, [2] overflow, [15:8] occupancy count (DATA_W >= 16 required); all other bits 0.
REQ-024 The queue SHALL be show-ahead: cmd_valid = !empty, and cmd_* present the oldest entry combinationally from storage.
REQ-025 A pop occurs on cmd_valid && cmd_ready; the next entry is visible the following cycle.
REQ-026 A COMMIT while full without a same-cycle pop is dropped and sets overflow; contents are unchanged.
REQ-027 A COMMIT while full with a same-cycle pop is accepted, count is unchanged, and overflow is not set.
REQ-028 A COMMIT while empty: cmd_valid rises the next cycle with the committed fields; it SHALL NOT bypass in the same cycle.
REQ-029 FLUSH wins over a same-cycle pop; the queue ends empty.
REQ-030 Pointers SHALL wrap modulo DEPTH; count spans 0..DEPTH and needs clog2(DEPTH)+1 bits.
REQ-031 Overflow SHALL stay set until cleared by REQ-018 or reset; a clear and a dropped commit cannot coincide (single address per cycle).

Reset
REQ-032 Asserting reset SHALL immediately zero X, Y, RADIUS, TYPE, readdata, pointers, count and overflow, and drive cmd_valid low, regardless of clock.
REQ-033 A reset mid-operation SHALL discard all queued entries; cmd_* values are don't-care while cmd_valid is 0.

Structure
REQ-034 Package sand_pkg SHALL hold the register address constants (ADDR_X=0 .. ADDR_FLUSH=6) and the STATUS bit positions.
REQ-035 The FIFO SHALL be the sub-module sand_cmd_fifo, parametrised by width and DEPTH, with push/pop/flush/full/empty/count.
REQ-036 The top SHALL contain the register decode, snapshot concatenation, overflow flag and read mux only.

Verification
REQ-037 Write X=0x12, Y=0x34, R=0x05, T=2, then COMMIT -> next cycle cmd_valid=1, cmd_x=0x12, cmd_y=0x34, cmd_radius=5, cmd_type=2, and STATUS reads 0x0100.
REQ-038 Hold cmd_ready=0 and perform 9 COMMITs with X=0..8 -> STATUS reads 0x0806 (count 8, full, overflow); popping drains X=0..7 in order.
REQ-039 While full, COMMIT with cmd_ready=1 in the same cycle -> count stays 8, overflow stays 0, and the newest entry appears last.
REQ-040 Queue holding 3 entries, FLUSH together with a pop -> next cycle cmd_valid=0 and STATUS=0x0001; a subsequent read of address 0 still returns the last X.
REQ-041 Assert reset asynchronously between edges with 5 entries queued -> cmd_valid falls before the next edge, and all readbacks return 0 after release.
REQ-042 Overflow set, write 0x0001 to address 5 -> STATUS bit 2 reads 0; writing 0x0000 instead leaves it at 1.
